// File: rtl/seq_detect_multi.sv
// seq_detect_multi: multi-channel 2-bit symbol sequence detector.
// Every channel tracks its own symbol stream against one shared, run-time
// loadable pattern and reports a registered match pulse (z1), a registered
// partial-match flag (z2) and a saturating match counter.
//
// rst_n asserts asynchronously. Its release is expected to be synchronous to
// clk (synchronised upstream), so the first edge after release is a normal
// working edge and no internal release stage delays it.
module seq_detect_multi #(
    parameter int                   CH      = 4,
    parameter int                   DEPTH   = 4,
    parameter int                   OVERLAP = 1,
    parameter int                   CNT_W   = 8,
    parameter logic [2*DEPTH-1:0]   RST_PAT = 8'b00_01_11_01
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [CH-1:0]         x1,
    input  logic [CH-1:0]         x2,
    input  logic                  load,
    input  logic [2*DEPTH-1:0]    pattern,
    input  logic                  clr_cnt,
    output logic [CH-1:0]         z1,
    output logic [CH-1:0]         z2,
    output logic [CH*CNT_W-1:0]   match_cnt
);

    localparam int              HW             = 2 * DEPTH;
    localparam int              FW             = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX        = '1;
    localparam bit              CLEAR_ON_MATCH = (OVERLAP == 0);

    logic [HW-1:0] pat_q;

    // Shared pattern register: reset value, replaced on load.
    // NOTE: state is always updated with non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= RST_PAT;
        end else if (load) begin
            pat_q <= pattern;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        // Only the newest DEPTH-1 symbols are stored; together with the
        // incoming symbol they form the full DEPTH-symbol window.
        // Symbol 0 (bits [1:0]) of the window is the oldest.
        logic [HW-3:0]      hist_q;
        logic [HW-1:0]      hist_d;
        logic [FW-1:0]      fill_q;
        logic [FW-1:0]      fill_d;
        logic               full_match;
        logic               partial;
        logic               suffix_ok;
        logic               hit;
        logic               z1_q;
        logic               z2_q;
        logic [CNT_W-1:0]   cnt_q;

        // Post-shift window, fill, full match and longest proper
        // suffix-prefix (only whether it is non-zero matters for z2).
        // NOTE: every variable gets a default at the top of the block so no
        // path leaves it unassigned and no latch is inferred.
        always_comb begin
            hist_d     = {x1[c], x2[c], hist_q};
            fill_d     = (fill_q == FW'(DEPTH)) ? fill_q : fill_q + FW'(1);
            full_match = (fill_d == FW'(DEPTH)) && (hist_d == pat_q);
            partial    = 1'b0;
            suffix_ok  = 1'b0;
            for (int k = 1; k < DEPTH; k++) begin
                suffix_ok = (FW'(k) <= fill_d);
                for (int j = 0; j < k; j++) begin
                    if (hist_d[2*(DEPTH-k+j) +: 2] != pat_q[2*j +: 2]) begin
                        suffix_ok = 1'b0;
                    end
                end
                if (suffix_ok) begin
                    partial = 1'b1;
                end
            end
        end

        // A counted match needs an enabled, non-load edge.
        assign hit = en && !load && full_match;

        // Per-channel tracking state and registered flags.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hist_q <= '0;
                fill_q <= '0;
                z1_q   <= 1'b0;
                z2_q   <= 1'b0;
            end else if (load) begin
                hist_q <= '0;
                fill_q <= '0;
                z1_q   <= 1'b0;
                z2_q   <= 1'b0;
            end else if (en) begin
                // Without overlap a match restarts tracking; the stale window
                // contents are harmless because fill gates every comparison.
                hist_q <= hist_d[HW-1:2];
                fill_q <= (full_match && CLEAR_ON_MATCH) ? '0 : fill_d;
                z1_q   <= full_match;
                z2_q   <= partial && !(full_match && CLEAR_ON_MATCH);
            end else begin
                z1_q   <= 1'b0;
            end
        end

        // Saturating match counter; clear wins over a simultaneous match.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (clr_cnt) begin
                cnt_q <= '0;
            end else if (hit && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        assign z1[c]                        = z1_q;
        assign z2[c]                        = z2_q;
        assign match_cnt[c*CNT_W +: CNT_W]  = cnt_q;
    end

endmodule

// File: tb/tb_seq_detect_multi.sv
// tb_seq_detect_multi: three detector instances (overlap, no overlap,
// 2-bit counters) share one stimulus stream and are compared every cycle
// against a queue-based reference model, plus directed scenario checks.
module tb_seq_detect_multi;

    localparam int              CH      = 4;
    localparam int              DEPTH   = 4;
    localparam int              HW      = 2 * DEPTH;
    localparam int              ND      = 3;
    localparam logic [HW-1:0]   DEF_PAT = 8'b00_01_11_01;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic            load;
    logic            clr_cnt;
    logic [CH-1:0]   x1;
    logic [CH-1:0]   x2;
    logic [HW-1:0]   pattern;
    logic [CH-1:0]   z1_w [ND];
    logic [CH-1:0]   z2_w [ND];
    logic [CH*8-1:0] cnt_ov;
    logic [CH*8-1:0] cnt_no;
    logic [CH*2-1:0] cnt_sat;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per (instance, channel) queue of symbols seen since
    // the last clear, never longer than DEPTH.
    logic [HW-1:0]   m_pat;
    int              mq [ND*CH][$];
    logic [CH-1:0]   e_z1 [ND];
    logic [CH-1:0]   e_z2 [ND];
    int              e_cnt [ND][CH];
    int              walk [CH];

    int dflt_syms [5] = '{0, 1, 3, 1, 0};
    int dflt_z2   [5] = '{0, 1, 1, 1, 0};
    int dflt_z1   [5] = '{0, 0, 0, 0, 1};
    int seq_syms  [4] = '{1, 3, 1, 0};

    seq_detect_multi #(.CH(CH), .DEPTH(DEPTH), .OVERLAP(1), .CNT_W(8), .RST_PAT(DEF_PAT)) u_ov (
        .clk(clk), .rst_n(rst_n), .en(en), .x1(x1), .x2(x2), .load(load),
        .pattern(pattern), .clr_cnt(clr_cnt), .z1(z1_w[0]), .z2(z2_w[0]), .match_cnt(cnt_ov)
    );

    seq_detect_multi #(.CH(CH), .DEPTH(DEPTH), .OVERLAP(0), .CNT_W(8), .RST_PAT(DEF_PAT)) u_no (
        .clk(clk), .rst_n(rst_n), .en(en), .x1(x1), .x2(x2), .load(load),
        .pattern(pattern), .clr_cnt(clr_cnt), .z1(z1_w[1]), .z2(z2_w[1]), .match_cnt(cnt_no)
    );

    seq_detect_multi #(.CH(CH), .DEPTH(DEPTH), .OVERLAP(1), .CNT_W(2), .RST_PAT(DEF_PAT)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .x1(x1), .x2(x2), .load(load),
        .pattern(pattern), .clr_cnt(clr_cnt), .z1(z1_w[2]), .z2(z2_w[2]), .match_cnt(cnt_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit overlaps(input int d);
        return d != 1;
    endfunction

    function automatic int cnt_max(input int d);
        return (d == 2) ? 3 : 255;
    endfunction

    function automatic int pat_sym(input int i);
        return int'(m_pat[2*i +: 2]);
    endfunction

    // Longest k in 1..DEPTH-1 whose last k symbols equal pattern prefix.
    function automatic int progress(input int q);
        int n;
        bit ok;
        n = mq[q].size();
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (k <= n) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    if (mq[q][n-k+j] != pat_sym(j)) ok = 1'b0;
                end
                if (ok) return k;
            end
        end
        return 0;
    endfunction

    function automatic logic [31:0] obs_cnt(input int d, input int c);
        case (d)
            0:       return 32'(cnt_ov[c*8 +: 8]);
            1:       return 32'(cnt_no[c*8 +: 8]);
            default: return 32'(cnt_sat[c*2 +: 2]);
        endcase
    endfunction

    task automatic model_reset();
        for (int q = 0; q < ND*CH; q++) mq[q].delete();
        for (int d = 0; d < ND; d++) begin
            e_z1[d] = '0;
            e_z2[d] = '0;
            for (int c = 0; c < CH; c++) e_cnt[d][c] = 0;
        end
        m_pat = DEF_PAT;
    endtask

    // Expected outputs after the coming edge, from the current inputs.
    task automatic model_edge();
        for (int d = 0; d < ND; d++) begin
            for (int c = 0; c < CH; c++) begin
                int q;
                bit full;
                q    = d*CH + c;
                full = 1'b0;
                if (load) begin
                    mq[q].delete();
                    e_z1[d][c] = 1'b0;
                    e_z2[d][c] = 1'b0;
                end else if (en) begin
                    mq[q].push_back(int'({x1[c], x2[c]}));
                    if (mq[q].size() > DEPTH) void'(mq[q].pop_front());
                    if (mq[q].size() == DEPTH) begin
                        full = 1'b1;
                        for (int i = 0; i < DEPTH; i++) begin
                            if (mq[q][i] != pat_sym(i)) full = 1'b0;
                        end
                    end
                    e_z1[d][c] = full;
                    if (full && !overlaps(d)) mq[q].delete();
                    e_z2[d][c] = (progress(q) != 0);
                    if (full && e_cnt[d][c] < cnt_max(d)) e_cnt[d][c]++;
                end else begin
                    e_z1[d][c] = 1'b0;
                end
                if (clr_cnt) e_cnt[d][c] = 0;
            end
        end
        if (load) m_pat = pattern;
    endtask

    task automatic compare_all(input string ph);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("%s z1 d%0d", ph, d), 32'(z1_w[d]), 32'(e_z1[d]));
            check($sformatf("%s z2 d%0d", ph, d), 32'(z2_w[d]), 32'(e_z2[d]));
            for (int c = 0; c < CH; c++) begin
                check($sformatf("%s cnt d%0d c%0d", ph, d, c), obs_cnt(d, c), e_cnt[d][c]);
            end
        end
    endtask

    task automatic step(input logic i_en, input logic [CH-1:0] i_x1, input logic [CH-1:0] i_x2,
                        input logic i_load, input logic i_clr, input string ph);
        en      = i_en;
        x1      = i_x1;
        x2      = i_x2;
        load    = i_load;
        clr_cnt = i_clr;
        model_edge();
        @(posedge clk);
        #1;
        compare_all(ph);
    endtask

    task automatic step_sym(input int ch, input logic [1:0] s, input logic i_clr, input string ph);
        logic [CH-1:0] v1;
        logic [CH-1:0] v2;
        v1     = '0;
        v2     = '0;
        v1[ch] = s[1];
        v2[ch] = s[0];
        step(1'b1, v1, v2, 1'b0, i_clr, ph);
    endtask

    // Reset asserted between edges and released on the falling edge.
    task automatic pulse_reset(input string ph);
        en      = 1'b0;
        load    = 1'b0;
        clr_cnt = 1'b0;
        rst_n   = 1'b0;
        model_reset();
        #1;
        compare_all(ph);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int p0;
        int p1;
        logic [CH-1:0] rx1;
        logic [CH-1:0] rx2;
        logic [1:0]    s;
        int r;

        rst_n = 1'b1; en = 1'b0; load = 1'b0; clr_cnt = 1'b0;
        x1 = '0; x2 = '0; pattern = DEF_PAT;
        for (int c = 0; c < CH; c++) walk[c] = 0;

        // Reset before any clock edge has occurred.
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all("reset");
        check("reset z1 d0", 32'(z1_w[0]), 0);
        check("reset cnt d0 c0", obs_cnt(0, 0), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Default pattern on channel 0.
        for (int i = 0; i < 5; i++) begin
            step_sym(0, 2'(dflt_syms[i]), 1'b0, "dflt");
            check($sformatf("dflt z2[0] edge%0d", i+1), 32'(z2_w[0][0]), dflt_z2[i]);
            check($sformatf("dflt z1[0] edge%0d", i+1), 32'(z1_w[0][0]), dflt_z1[i]);
        end
        check("dflt cnt c0", obs_cnt(0, 0), 1);
        for (int c = 1; c < CH; c++) check($sformatf("dflt cnt c%0d", c), obs_cnt(0, c), 0);

        // Self-overlapping pattern on channel 1.
        pattern = 8'b01_01_01_01;
        step(1'b0, '0, '0, 1'b1, 1'b0, "load_ov");
        p0 = 0;
        p1 = 0;
        for (int i = 0; i < 8; i++) begin
            step_sym(1, 2'b01, 1'b0, "ov");
            if (z1_w[0][1] === 1'b1) p0++;
            if (z1_w[1][1] === 1'b1) p1++;
            if (i < 7) check($sformatf("ov z1 edge%0d", i+1), 32'(z1_w[0][1]), (i >= 3) ? 1 : 0);
            if (i == 6) begin
                check("ov pulses", p0, 4);
                check("nov pulses", p1, 1);
                check("ov cnt", obs_cnt(0, 1), 4);
                check("nov cnt", obs_cnt(1, 1), 1);
            end
        end
        check("nov pulses after 8th", p1, 2);

        // Enable gating on channel 2 with default pattern.
        pattern = DEF_PAT;
        step(1'b0, '0, '0, 1'b1, 1'b0, "load_def");
        step(1'b0, '0, '0, 1'b0, 1'b1, "clr");
        for (int i = 0; i < 4; i++) begin
            step_sym(2, 2'(seq_syms[i]), 1'b0, "gate");
            check($sformatf("gate z1 sym%0d", i+1), 32'(z1_w[0][2]), (i == 3) ? 1 : 0);
            for (int g = 0; g < 3; g++) begin
                rx1 = CH'($urandom);
                rx2 = CH'($urandom);
                step(1'b0, rx1, rx2, 1'b0, 1'b0, "gap");
                check("gap z1", 32'(z1_w[0][2]), 0);
                check("gap z2 hold", 32'(z2_w[0][2]), (i < 3) ? 1 : 0);
            end
        end

        // Saturation and clear priority on channel 3.
        step(1'b0, '0, '0, 1'b0, 1'b1, "clr");
        for (int m = 0; m < 5; m++) begin
            for (int i = 0; i < 4; i++) step_sym(3, 2'(seq_syms[i]), 1'b0, "sat");
        end
        check("sat cnt w2", obs_cnt(2, 3), 3);
        check("sat cnt w8", obs_cnt(0, 3), 5);
        for (int i = 0; i < 3; i++) step_sym(3, 2'(seq_syms[i]), 1'b0, "sat");
        step_sym(3, 2'b00, 1'b1, "sat_clr");
        check("clr+match cnt", obs_cnt(2, 3), 0);
        check("clr+match z1", 32'(z1_w[2][3]), 1);
        for (int i = 0; i < 4; i++) step_sym(3, 2'(seq_syms[i]), 1'b0, "sat");
        check("after clr cnt", obs_cnt(2, 3), 1);

        // Load mid-sequence discards progress.
        for (int i = 0; i < 3; i++) step_sym(0, 2'(seq_syms[i]), 1'b0, "mid");
        pattern = DEF_PAT;
        step(1'b1, '0, '0, 1'b1, 1'b0, "mid_load");
        check("mid load z2", 32'(z2_w[0][0]), 0);
        step_sym(0, 2'b00, 1'b0, "mid");
        check("mid load no match", 32'(z1_w[0][0]), 0);

        // Reset mid-sequence discards progress and counters.
        for (int i = 0; i < 3; i++) step_sym(0, 2'(seq_syms[i]), 1'b0, "mid");
        pulse_reset("mid_rst");
        check("mid rst z2", 32'(z2_w[0][0]), 0);
        check("mid rst cnt", obs_cnt(0, 3), 0);
        step_sym(0, 2'b00, 1'b0, "mid");
        check("mid rst no match", 32'(z1_w[0][0]), 0);

        // Randomised traffic, biased toward walking through the pattern.
        for (int n = 0; n < 500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                pattern = (r == 0) ? DEF_PAT : HW'($urandom);
                step(1'($urandom_range(0, 1)), CH'($urandom), CH'($urandom), 1'b1, 1'b0, "rnd_load");
            end else begin
                for (int c = 0; c < CH; c++) begin
                    if ($urandom_range(0, 9) < 7) begin
                        s       = 2'(pat_sym(walk[c]));
                        walk[c] = (walk[c] + 1) % DEPTH;
                    end else begin
                        s = 2'($urandom_range(0, 3));
                    end
                    rx1[c] = s[1];
                    rx2[c] = s[0];
                end
                step(1'($urandom_range(0, 3) != 0), rx1, rx2, 1'b0,
                     1'($urandom_range(0, 99) < 3), "rnd");
            end
            if (n == 250) pulse_reset("rnd_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
